// File: rtl/color_pkg.sv
`default_nettype none
// ============================================================================
// Module      : color_pkg
// Description : Shared types and encodings for the Color FSM and its driver.
// Revision    : 1.0 - initial release
// ============================================================================
package color_pkg;

    // Target colour requested by software
    typedef enum logic {
        COLOR_BLUE = 1'b0,
        COLOR_RED  = 1'b1
    } color_e;

    // Command codes driven onto the Color FSM `in` pins
    localparam logic [1:0] CMD_TOGGLE = 2'h1;
    localparam logic [1:0] CMD_NOP    = 2'h2;

    // Status codes reported on the Color FSM `out` pins
    localparam logic [1:0] STS_BLUE   = 2'h1;
    localparam logic [1:0] STS_RED    = 2'h2;

    // Driver control states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } drv_state_e;

    // Only the Blue and Red codes are meaningful; anything else is a fault
    function automatic logic sts_is_legal(input logic [1:0] sts);
        return (sts == STS_BLUE) || (sts == STS_RED);
    endfunction

    // True when the reported status is exactly the requested colour
    function automatic logic sts_matches(input logic [1:0] sts, input color_e color);
        return (color == COLOR_RED) ? (sts == STS_RED) : (sts == STS_BLUE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/color_fsm_driver_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones, with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] r_count;

    // Clear wins over increment; increment is suppressed once all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/color_fsm_driver.sv
`default_nettype none
// ============================================================================
// Module      : color_fsm_driver
// Description : Accepts colour requests, issues a TOGGLE to the Color FSM
//               when needed, and reports success/timeout with a cycle count.
//               Also tracks a saturating count of Red status cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module color_fsm_driver
    import color_pkg::*;
#(
    parameter int TIMEOUT   = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_color,
    output logic                 req_ready,
    output logic [1:0]           cmd_out,
    input  logic [1:0]           status_in,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic                 done_ok,
    output logic [CNT_WIDTH-1:0] done_cycles,
    output logic [CNT_WIDTH-1:0] red_cycles
);

    localparam int                   c_CNT_MAX = (1 << CNT_WIDTH) - 1;
    localparam logic [CNT_WIDTH-1:0] c_TIMEOUT = CNT_WIDTH'(TIMEOUT);

    // The wait counter must be able to reach TIMEOUT before it saturates
    generate
        if ((TIMEOUT < 1) || (TIMEOUT > c_CNT_MAX)) begin : g_bad_timeout
            $error("color_fsm_driver: TIMEOUT must be in 1..2^CNT_WIDTH-1");
        end
    endgenerate

    drv_state_e           r_state;
    color_e               r_target;
    logic [1:0]           r_cmd;
    logic                 r_req_ready;
    logic                 r_done_valid;
    logic                 r_done_ok;
    logic [CNT_WIDTH-1:0] r_done_cycles;

    logic [CNT_WIDTH-1:0] w_cyc;
    logic                 w_cyc_inc;
    logic                 w_cyc_clr;
    logic                 w_req_match;
    logic                 w_tgt_match;
    logic                 w_illegal;
    logic                 w_timeout;
    logic                 w_red_inc;

    assign w_req_match = sts_matches(status_in, color_e'(req_color));
    assign w_tgt_match = sts_matches(status_in, r_target);
    assign w_illegal   = !sts_is_legal(status_in);
    assign w_timeout   = (w_cyc == c_TIMEOUT);
    assign w_red_inc   = (status_in == STS_RED);

    // Cycle counter control: cleared on acceptance, advanced while in flight
    always_comb begin
        w_cyc_clr = 1'b0;
        w_cyc_inc = 1'b0;
        case (r_state)
            ST_IDLE:  w_cyc_clr = req_valid;
            ST_ISSUE: w_cyc_inc = 1'b1;
            ST_WAIT:  w_cyc_inc = !w_tgt_match && !w_illegal && !w_timeout;
            default:  ;
        endcase
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_cyc_inc),
        .clr   (w_cyc_clr),
        .count (w_cyc)
    );

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_red_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_red_inc),
        .clr   (1'b0),
        .count (red_cycles)
    );

    // Request/command/response state machine with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_target      <= COLOR_BLUE;
            r_cmd         <= CMD_NOP;
            r_req_ready   <= 1'b1;
            r_done_valid  <= 1'b0;
            r_done_ok     <= 1'b0;
            r_done_cycles <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_target    <= color_e'(req_color);
                        r_req_ready <= 1'b0;
                        if (w_req_match || w_illegal) begin
                            // Already there (or FSM faulted): answer without a toggle
                            r_state       <= ST_RESPOND;
                            r_done_valid  <= 1'b1;
                            r_done_ok     <= w_req_match;
                            r_done_cycles <= '0;
                        end else begin
                            r_state <= ST_ISSUE;
                            r_cmd   <= CMD_TOGGLE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // TOGGLE is a single-cycle pulse
                    r_cmd   <= CMD_NOP;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_tgt_match || w_illegal || w_timeout) begin
                        r_state       <= ST_RESPOND;
                        r_done_valid  <= 1'b1;
                        r_done_ok     <= w_tgt_match;
                        r_done_cycles <= w_cyc;
                    end
                end
                ST_RESPOND: begin
                    if (done_ready) begin
                        r_state      <= ST_IDLE;
                        r_done_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd       <= CMD_NOP;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign cmd_out     = r_cmd;
    assign done_valid  = r_done_valid;
    assign done_ok     = r_done_ok;
    assign done_cycles = r_done_cycles;

endmodule
`default_nettype wire

// File: tb/tb_color_fsm_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_color_fsm_driver
// Description : Directed self-checking bench for color_fsm_driver with a
//               behavioural Color FSM model and a completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_color_fsm_driver;

    localparam int TIMEOUT   = 8;
    localparam int CNT_WIDTH = 4;

    typedef struct packed {
        logic                 ok;
        logic [CNT_WIDTH-1:0] cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_color;
    logic                 req_ready;
    logic [1:0]           cmd_out;
    logic [1:0]           status_in;
    logic                 done_valid;
    logic                 done_ready;
    logic                 done_ok;
    logic [CNT_WIDTH-1:0] done_cycles;
    logic [CNT_WIDTH-1:0] red_cycles;

    // Color FSM model controls
    logic       model_red;
    logic       stuck;
    logic       use_force;
    logic [1:0] force_sts;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_toggle = 0;
    exp_t exp_q[$];

    color_fsm_driver #(
        .TIMEOUT   (TIMEOUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_color   (req_color),
        .req_ready   (req_ready),
        .cmd_out     (cmd_out),
        .status_in   (status_in),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .done_ok     (done_ok),
        .done_cycles (done_cycles),
        .red_cycles  (red_cycles)
    );

    always #5 clk = ~clk;

    // Color FSM: resets to Red, flips on TOGGLE unless held stuck
    always @(posedge clk or negedge rst) begin
        if (!rst)
            model_red <= 1'b1;
        else if (cmd_out == 2'h1 && !stuck)
            model_red <= ~model_red;
    end

    assign status_in = use_force ? force_sts : (model_red ? 2'h2 : 2'h1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and note any TOGGLE on the bus
    task automatic tick();
        @(negedge clk);
        if (cmd_out == 2'h1) n_toggle++;
    endtask

    task automatic push_exp(input logic ok, input int cyc);
        exp_t e;
        e.ok  = ok;
        e.cyc = CNT_WIDTH'(cyc);
        exp_q.push_back(e);
    endtask

    task automatic compare_done();
        exp_t e;
        check("sb_has_entry", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("done_ok", {31'd0, done_ok}, {31'd0, e.ok});
            check("done_cycles", {28'd0, done_cycles}, {28'd0, e.cyc});
        end
    endtask

    task automatic run_request(input logic color, input logic exp_ok, input int exp_cyc,
                               input int exp_lat, input int exp_tog, input bit inject_illegal);
        int k;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        push_exp(exp_ok, exp_cyc);
        req_valid = 1'b1;
        req_color = color;
        n_toggle  = 0;
        tick();
        req_valid = 1'b0;
        if (inject_illegal) begin
            use_force = 1'b1;
            force_sts = 2'h3;
        end
        k = 1;
        while (!done_valid && k < 40) begin
            tick();
            k++;
        end
        check("latency", k, exp_lat);
        check("toggles", n_toggle, exp_tog);
        compare_done();
    endtask

    task automatic release_done();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("done_valid_clr", {31'd0, done_valid}, 32'd0);
        check("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic seen;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_color  = 1'b0;
        done_ready = 1'b0;
        stuck      = 1'b0;
        use_force  = 1'b0;
        force_sts  = 2'h0;

        // Reset state
        repeat (3) tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_cmd_out", {30'd0, cmd_out}, 32'h2);
        check("rst_done_valid", {31'd0, done_valid}, 32'd0);
        check("rst_done_ok", {31'd0, done_ok}, 32'd0);
        check("rst_done_cycles", {28'd0, done_cycles}, 32'd0);
        check("rst_red_cycles", {28'd0, red_cycles}, 32'd0);
        rst = 1'b1;
        tick();

        // FSM is Red: Blue needs one toggle, confirmed on the first Wait cycle
        run_request(1'b0, 1'b1, 1, 3, 1, 1'b0);
        release_done();
        // FSM is Blue: Red needs one toggle
        run_request(1'b1, 1'b1, 1, 3, 1, 1'b0);
        release_done();
        // FSM is Red: Red is already satisfied, no toggle
        run_request(1'b1, 1'b1, 0, 1, 0, 1'b0);
        release_done();

        // Stuck FSM: single toggle, then timeout at TIMEOUT
        stuck = 1'b1;
        run_request(1'b0, 1'b0, TIMEOUT, TIMEOUT + 2, 1, 1'b0);
        release_done();

        // Illegal status seen in Wait aborts at once; req_ready held low
        run_request(1'b0, 1'b0, 1, 3, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("illegal_req_ready_low", {31'd0, req_ready}, 32'd0);
        end
        use_force = 1'b0;
        release_done();

        // Respond held for 5 cycles; a stray request must be ignored
        run_request(1'b1, 1'b1, 0, 1, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 2);
            req_color = 1'b0;
            tick();
            check("hold_done_valid", {31'd0, done_valid}, 32'd1);
            check("hold_done_ok", {31'd0, done_ok}, 32'd1);
            check("hold_done_cycles", {28'd0, done_cycles}, 32'd0);
        end
        // Request offered alongside done_ready is taken only on the next cycle
        done_ready = 1'b1;
        req_valid  = 1'b1;
        req_color  = 1'b1;
        push_exp(1'b1, 0);
        tick();
        done_ready = 1'b0;
        check("b2b_idle_done_valid", {31'd0, done_valid}, 32'd0);
        check("b2b_idle_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("b2b_accept_done_valid", {31'd0, done_valid}, 32'd1);
        compare_done();
        release_done();

        // Red-count saturation from a fresh reset with status Red
        stuck = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        check("sat_reset_red", {28'd0, red_cycles}, 32'd0);
        rst = 1'b1;
        repeat (10) tick();
        check("red_count_10", {28'd0, red_cycles}, 32'd10);
        repeat (10) tick();
        check("red_count_sat", {28'd0, red_cycles}, 32'd15);

        // Asynchronous reset during Wait aborts without a completion
        stuck     = 1'b1;
        req_valid = 1'b1;
        req_color = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        check("abort_in_wait", {31'd0, req_ready}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_cmd_out", {30'd0, cmd_out}, 32'h2);
        check("abort_done_valid", {31'd0, done_valid}, 32'd0);
        check("abort_done_ok", {31'd0, done_ok}, 32'd0);
        check("abort_done_cycles", {28'd0, done_cycles}, 32'd0);
        check("abort_red_cycles", {28'd0, red_cycles}, 32'd0);
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | done_valid;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/color_fsm_driver.md
Name: color_fsm_driver

Overview:
- Initiator-side controller for the two-state Color FSM. It accepts "go to colour X" requests over a valid/ready handshake, emits the 2-bit command stream the Color FSM consumes, and watches the FSM's 2-bit status code until it confirms the target or a timeout expires.
- Also keeps a saturating count of cycles in which the FSM reports Red.
- Sits between a software-visible request register and the Color FSM's `in`/`out` pins.

Parameters:
- TIMEOUT, 8, max Wait-state cycles before the request is abandoned (≥1).
- CNT_WIDTH, 8, width of `done_cycles` and `red_cycles`.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_color  in  1  target colour: 0=Blue, 1=Red
- req_ready  out  1  driver can accept a request
- cmd_out  out  2  to FSM `in`: 2'h1=TOGGLE, 2'h2=NOP
- status_in  in  2  from FSM `out`: 2'h1=Blue, 2'h2=Red, others illegal
- done_valid  out  1  completion record valid
- done_ready  in  1  completion consumed
- done_ok  out  1  1=target reached, 0=timeout or illegal status
- done_cycles  out  CNT_WIDTH  cycles from acceptance to confirmation
- red_cycles  out  CNT_WIDTH  saturating count of cycles with status_in==2'h2

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, on `rst`.
- Reset values:
  - state=Idle, cmd_out=NOP, req_ready=1, done_valid=0, done_ok=0, done_cycles=0, red_cycles=0.
  - Reset mid-operation aborts immediately. No completion record is produced for the aborted request.
- States: Idle, Issue, Wait, Respond.
- Idle:
  - req_ready=1, cmd_out=NOP.
  - On req_valid: latch req_color into target, clear cyc.
  - If status_in already encodes target: go to Respond with ok=1, cycles=0.
  - If status_in is illegal: go to Respond with ok=0.
  - Otherwise go to Issue.
- Issue:
  - cmd_out=TOGGLE for exactly one cycle, cyc+=1, then go to Wait.
- Wait:
  - cmd_out=NOP, req_ready=0.
  - The FSM has one-cycle latency, so a match normally appears on the first Wait cycle.
  - Each cycle:
    - status matches target: Respond with ok=1, done_cycles=cyc.
    - otherwise, if status is illegal or cyc==TIMEOUT: Respond with ok=0, done_cycles=cyc.
    - otherwise: cyc+=1.
  - If the FSM moves to the wrong colour, TOGGLE is not re-issued; the request times out.
- Respond:
  - done_valid=1; done_ok and done_cycles are held stable.
  - On done_ready=1: go to Idle, done_valid=0 next cycle.
  - A new request is not accepted in the same cycle as done_ready. The earliest acceptance is the following cycle.
- Latency: a toggle request whose colour is confirmed on the first Wait cycle has done_valid asserted 3 cycles after acceptance (Idle→Issue→Wait→Respond), with done_cycles=1.
- cyc counter: CNT_WIDTH wide, saturates at all-ones. TIMEOUT > 2^CNT_WIDTH-1 is illegal; flag it with an elaboration-time assertion.
- red_cycles:
  - Increments in every state whenever status_in==2'h2.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - Cleared only by reset.
- req_ready is a registered function of state only. cmd_out is a registered output, so TOGGLE reaches the FSM in the Issue cycle.

Decomposition:
- Shared package color_pkg:
  - Color enum: Blue=1'h0, Red=1'h1.
  - Command constants: CMD_TOGGLE=2'h1, CMD_NOP=2'h2.
  - Status codes: STS_BLUE=2'h1, STS_RED=2'h2.
  - Driver state enum.
- One natural sub-module: sat_counter (CNT_WIDTH, inc, clr), instantiated for cyc and red_cycles.

Test Plan:
- Reset with status_in=2'h2 (FSM resets to Red), request Blue:
  - TOGGLE for one cycle, FSM model reports 2'h1 on the next cycle.
  - Expect done_valid 3 cycles after acceptance, done_ok=1, done_cycles=1.
- Status=2'h2, request Red:
  - No TOGGLE issued; Respond on the next cycle with done_ok=1, done_cycles=0.
- Stuck FSM model (status held 2'h2), request Blue, TIMEOUT=8:
  - Exactly one TOGGLE pulse, then done_ok=0, done_cycles=8.
- Illegal status 2'h3 during Wait:
  - Immediate Respond with done_ok=0; req_ready stays 0 until done_ready.
- Hold done_ready=0 for 5 cycles in Respond:
  - done_valid, done_ok and done_cycles stay stable; a req_valid pulse is ignored; after done_ready, the next request is accepted one cycle later.
- Red saturation and reset abort:
  - CNT_WIDTH=4, status=2'h2 for 20 cycles → red_cycles=15 and holds.
  - Assert rst low during Wait → all outputs return to their reset values asynchronously, and no done_valid appears.
